// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller.
// Arbitrates redirects (EX jump/branch, trap unit) against pipeline holds
// (bus wait, multi-cycle EX, load-use) and produces stall/flush controls for
// the PC, IF/ID and ID/EX registers. Also counts stalled cycles.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   jump_req_i/addr_i   EX redirect request (pulse) and target
//   int_req_i/addr_i    trap-unit redirect request (pulse) and vector
//   mem_wait_i          bus not ready, freeze whole pipe
//   hold_ex_i           multi-cycle EX op busy
//   load_use_i          load-use hazard in ID
//   stall_o[3:0]        stall vector {EX, ID, IF, PC}
//   flush_o             flush all inter-stage registers
//   flush_addr_o        new PC while flush_o=1, else 0
//   ex_bubble_o         ID inserts a bubble into ID/EX
//   stall_cnt_o         saturating count of cycles with any stall bit set
module pipe_ctrl #(
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_req_i,
    input  logic [31:0] int_addr_i,
    input  logic        mem_wait_i,
    input  logic        hold_ex_i,
    input  logic        load_use_i,
    output logic [3:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] flush_addr_o,
    output logic        ex_bubble_o,
    output logic [31:0] stall_cnt_o
);

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned STALL_W   = 4;
    localparam logic [STALL_W-1:0] STALL_ALL  = 4'b1111;
    localparam logic [STALL_W-1:0] STALL_LU   = 4'b0111;
    localparam logic [CNT_W-1:0]   FLUSH_RELOAD = CNT_W'(FLUSH_LEN - 1);
    localparam bit                 MULTI_FLUSH  = (FLUSH_LEN > 1);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WAIT   = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         stall_cnt_q;

    logic                req;
    logic [ADDR_W-1:0]   target;

    // Interrupt wins over a simultaneous jump.
    assign req    = int_req_i | jump_req_i;
    assign target = int_req_i ? int_addr_i : jump_addr_i;

    // State, flush counter and latched redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        stall_o      = '0;
        flush_o      = 1'b0;
        flush_addr_o = '0;
        ex_bubble_o  = 1'b0;

        case (state_q)
            NORMAL: begin
                if (req) begin
                    if (!mem_wait_i) begin
                        flush_o      = 1'b1;
                        flush_addr_o = target;
                        if (MULTI_FLUSH) begin
                            addr_d  = target;
                            cnt_d   = FLUSH_RELOAD;
                            state_d = FLUSH;
                        end
                    end else begin
                        // Bus busy: hold the redirect until the pipe can move.
                        stall_o = STALL_ALL;
                        addr_d  = target;
                        state_d = WAIT;
                    end
                end else if (mem_wait_i || hold_ex_i) begin
                    stall_o = STALL_ALL;
                end else if (load_use_i) begin
                    // EX keeps moving; ID feeds it a bubble.
                    stall_o     = STALL_LU;
                    ex_bubble_o = 1'b1;
                end
            end

            WAIT: begin
                if (int_req_i) begin
                    addr_d = int_addr_i;
                end
                if (mem_wait_i) begin
                    stall_o = STALL_ALL;
                end else begin
                    flush_o      = 1'b1;
                    flush_addr_o = int_req_i ? int_addr_i : addr_q;
                    if (MULTI_FLUSH) begin
                        cnt_d   = FLUSH_RELOAD;
                        state_d = FLUSH;
                    end else begin
                        state_d = NORMAL;
                    end
                end
            end

            FLUSH: begin
                flush_o = 1'b1;
                if (int_req_i) begin
                    // A trap restarts the flush toward its vector.
                    flush_addr_o = int_addr_i;
                    addr_d       = int_addr_i;
                    cnt_d        = FLUSH_RELOAD;
                end else begin
                    flush_addr_o = addr_q;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = NORMAL;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((stall_o != '0) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl (FLUSH_LEN=2).
// Each cycle's expected controls are queued when stimulus is applied and
// compared by a negedge monitor; stall_cnt_o is checked inline per test.
module tb_pipe_ctrl;

    typedef struct {
        logic [3:0]  stall;
        logic        flush;
        logic [31:0] addr;
        logic        bubble;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        int_req_i;
    logic [31:0] int_addr_i;
    logic        mem_wait_i;
    logic        hold_ex_i;
    logic        load_use_i;
    logic [3:0]  stall_o;
    logic        flush_o;
    logic [31:0] flush_addr_o;
    logic        ex_bubble_o;
    logic [31:0] stall_cnt_o;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 32'd0;

    pipe_ctrl #(.FLUSH_LEN(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_req_i   (jump_req_i),
        .jump_addr_i  (jump_addr_i),
        .int_req_i    (int_req_i),
        .int_addr_i   (int_addr_i),
        .mem_wait_i   (mem_wait_i),
        .hold_ex_i    (hold_ex_i),
        .load_use_i   (load_use_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .flush_addr_o (flush_addr_o),
        .ex_bubble_o  (ex_bubble_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (stall_o !== e.stall || flush_o !== e.flush ||
                flush_addr_o !== e.addr || ex_bubble_o !== e.bubble) begin
                errors++;
                $display("FAIL %s: got stall=%b flush=%b addr=%h bubble=%b, want stall=%b flush=%b addr=%h bubble=%b",
                         e.tag, stall_o, flush_o, flush_addr_o, ex_bubble_o,
                         e.stall, e.flush, e.addr, e.bubble);
            end
        end
    end

    // One clock: apply inputs, queue expected outputs, advance past the edge
    // and update the reference stall counter.
    task automatic cycle(input string tag, input logic rst,
                         input logic jreq, input logic [31:0] jaddr,
                         input logic ireq, input logic [31:0] iaddr,
                         input logic mw, input logic hx, input logic lu,
                         input logic [3:0] e_stall, input logic e_flush,
                         input logic [31:0] e_addr, input logic e_bub);
        exp_t e;
        rst_n       = rst;
        jump_req_i  = jreq;
        jump_addr_i = jaddr;
        int_req_i   = ireq;
        int_addr_i  = iaddr;
        mem_wait_i  = mw;
        hold_ex_i   = hx;
        load_use_i  = lu;
        e.stall  = e_stall;
        e.flush  = e_flush;
        e.addr   = e_addr;
        e.bubble = e_bub;
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!rst) exp_cnt = 32'd0;
        else if (e_stall != 4'd0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic idle(input string tag, input logic [3:0] e_stall, input logic e_flush,
                        input logic [31:0] e_addr);
        cycle(tag, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
              e_stall, e_flush, e_addr, 1'b0);
    endtask

    task automatic test_reset();
        cycle("rst0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        cycle("rst1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        idle("post_reset", 4'h0, 1'b0, 32'h0);
        checks++;
        if (stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h want 0", stall_cnt_o);
        end
    endtask

    task automatic test_jump();
        cycle("jump_c0", 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h200, 1'b0);
        idle("jump_c1", 4'h0, 1'b1, 32'h200);
        idle("jump_end", 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_jump_mem_wait();
        cycle("jw_c0", 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0);
        // A jump in WAIT must be ignored.
        cycle("jw_c1", 1'b1, 1'b1, 32'h999, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0);
        cycle("jw_c2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0);
        idle("jw_rel0", 4'h0, 1'b1, 32'h300);
        idle("jw_rel1", 4'h0, 1'b1, 32'h300);
        idle("jw_end", 4'h0, 1'b0, 32'h0);
        checks++;
        if (stall_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL jw_cnt: got %h want %h", stall_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_int_vs_jump();
        cycle("ij_c0", 1'b1, 1'b1, 32'h400, 1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h8000_0004, 1'b0);
        cycle("ij_c1", 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h8000_0010, 1'b0);
        idle("ij_c2", 4'h0, 1'b1, 32'h8000_0010);
        idle("ij_end", 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_flush_priority();
        // Holds and jumps during FLUSH are ignored; countdown continues.
        cycle("fp_c0", 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h500, 1'b0);
        cycle("fp_c1", 1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 32'h500, 1'b0);
        cycle("fp_end", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_hazards();
        cycle("hz_rst", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
        cycle("hz_lu", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle("hz_hold", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0);
        end
        idle("hz_end", 4'h0, 1'b0, 32'h0);
        checks++;
        if (stall_cnt_o !== 32'd5) begin
            errors++;
            $display("FAIL hz_cnt: got %0d want 5", stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_flush();
        cycle("rf_c0", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h100, 1'b0);
        cycle("rf_rst", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h100, 1'b0);
        idle("rf_after", 4'h0, 1'b0, 32'h0);
        checks++;
        if (stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL rf_cnt: got %h want 0", stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        cycle("rw_c0", 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0);
        cycle("rw_rst", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0);
        // Pending redirect discarded: no flush once the bus frees up.
        idle("rw_after", 4'h0, 1'b0, 32'h0);
        idle("rw_after2", 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_saturate();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            cycle("sat_wait", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 32'h0, 1'b0);
            checks++;
            if (stall_cnt_o !== 32'hFFFF_FFFF || stall_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: got %h want ffffffff", i, stall_cnt_o);
            end
        end
        idle("sat_end", 4'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        jump_req_i = 1'b0; jump_addr_i = '0;
        int_req_i = 1'b0;  int_addr_i = '0;
        mem_wait_i = 1'b0; hold_ex_i = 1'b0; load_use_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_jump();
        test_jump_mem_wait();
        test_int_vs_jump();
        test_flush_priority();
        test_hazards();
        test_reset_mid_flush();
        test_reset_mid_wait();
        test_saturate();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller. It drives the stall vector and flush/redirect signals consumed by every inter-stage register (PC, IF/ID, ID/EX). It arbitrates redirect requests from EX (jump/branch) and the trap unit (interrupt/exception) against hold conditions: bus wait, multi-cycle EX op, and load-use hazard. It also keeps a stall-cycle performance counter.

Parameters:
- FLUSH_LEN, 2, total cycles flush_o stays high per redirect (legal range 1..15); covers in-flight fetches from the old path.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- jump_req_i  in  1  EX redirect request (taken branch/jump), single-cycle pulse
- jump_addr_i  in  32  EX redirect target
- int_req_i  in  1  trap-unit redirect request, single-cycle pulse
- int_addr_i  in  32  trap vector target
- mem_wait_i  in  1  data/instruction bus not ready; freeze whole pipe
- hold_ex_i  in  1  multi-cycle EX op (mul/div) busy
- load_use_i  in  1  load-use hazard detected in ID
- stall_o  out  `STALL_WIDTH  stall vector; bit `STALL_PC`=0, `STALL_IF`=1, `STALL_ID`=2, `STALL_EX`=3
- flush_o  out  1  flush all inter-stage registers
- flush_addr_o  out  32  new PC, valid while flush_o=1, else 0
- ex_bubble_o  out  1  ID must present inst_valid=0 / zero decode info to ID/EX this cycle
- stall_cnt_o  out  32  cycles with any stall_o bit set, saturating

Behaviour:
- States: NORMAL, WAIT (redirect pending behind mem_wait), FLUSH (extended flush). Register reset (rst_n=0 at a clk edge) -> state=NORMAL, flush counter=0, pending addr=0, stall_cnt=0. All outputs are 0 in the cycle after reset, including when reset lands mid-FLUSH or mid-WAIT; the pending redirect is discarded.
- Redirect request: req = int_req_i | jump_req_i. Target = int_addr_i if int_req_i, else jump_addr_i (interrupt wins).
- NORMAL, req=1, mem_wait_i=0:
  - Combinational: flush_o=1, flush_addr_o=target, stall_o=0, ex_bubble_o=0.
  - If FLUSH_LEN>1: latch target, load counter=FLUSH_LEN-1, go to FLUSH. Otherwise stay in NORMAL.
- NORMAL, req=1, mem_wait_i=1: latch target as pending, go to WAIT. Outputs: stall_o=4'b1111, flush_o=0.
- NORMAL, req=0, stall priority:
  - mem_wait_i or hold_ex_i -> stall_o=4'b1111, ex_bubble_o=0.
  - else load_use_i -> stall_o=4'b0111, ex_bubble_o=1.
  - else stall_o=0.
- WAIT:
  - stall_o=4'b1111 while mem_wait_i=1.
  - int_req_i=1 overwrites pending with int_addr_i. jump_req_i is ignored.
  - When mem_wait_i=0: flush_o=1, flush_addr_o=pending, stall_o=0. Then enter FLUSH with counter=FLUSH_LEN-1, or NORMAL if FLUSH_LEN=1.
- FLUSH:
  - flush_o=1, flush_addr_o=latched target, stall_o=0, ex_bubble_o=0.
  - Counter decrements each cycle; exit to NORMAL after the cycle in which counter=1.
  - jump_req_i and load_use_i/hold_ex_i are ignored.
  - int_req_i restarts the flush: flush_addr_o=int_addr_i that cycle, latch it, counter reloads to FLUSH_LEN-1.
  - mem_wait_i during FLUSH still counts down; flush has priority over stall.
- Simultaneous int_req_i and jump_req_i: a single redirect to int_addr_i.
- flush_addr_o=0 whenever flush_o=0.
- stall_cnt_o increments on every clock where stall_o!=0 (registered, visible next cycle). Saturates at 32'hFFFF_FFFF (no wrap).

Test Plan:
- Reset mid-flush: jump_req_i=1, jump_addr_i=32'h100, then rst_n=0 one cycle later -> after reset edge, flush_o=0, stall_o=0, stall_cnt_o=0, state NORMAL.
- Jump with FLUSH_LEN=2: jump_req_i pulse, jump_addr_i=32'h0000_0200 -> flush_o=1 for exactly 2 cycles with flush_addr_o=32'h200, stall_o=0 throughout, then flush_o=0 and flush_addr_o=0.
- Jump while mem_wait_i=1 held 3 cycles: jump_addr_i=32'h300 -> stall_o=4'b1111 for 3 cycles, no flush; on the cycle mem_wait_i falls, flush_o=1 with flush_addr_o=32'h300 for 2 cycles.
- Simultaneous int_req_i (int_addr_i=32'h8000_0004) and jump_req_i (jump_addr_i=32'h400) -> flush_addr_o=32'h8000_0004; a second int_req_i (int_addr_i=32'h8000_0010) in the next cycle (FLUSH) -> flush_addr_o=32'h8000_0010, flush extended 2 more cycles.
- load_use_i=1 for 1 cycle, then hold_ex_i=1 for 4 cycles -> stall_o=4'b0111 with ex_bubble_o=1 for 1 cycle, then stall_o=4'b1111 with ex_bubble_o=0 for 4 cycles; stall_cnt_o reads 5.
- Force stall_cnt to 32'hFFFF_FFFE, hold mem_wait_i=1 for 3 cycles -> stall_cnt_o reaches 32'hFFFF_FFFF and stays there.
